// File: rtl/reg_scoreboard.sv
// Register write scoreboard: one 2-bit pending-write counter per register
// x1..x31. It stalls ID on RAW hazards and on counter exhaustion, and it
// flags protocol violations (underflow/overflow) in a sticky error bit.
module reg_scoreboard (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic       issue_reg_write,
  input  logic [4:0] issue_rd,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       kill_valid,
  input  logic [4:0] kill_rd,
  output logic       is_stall,
  output logic       pending_any,
  output logic       sb_error
);

  // Registered counters (stage 1) and their combinational next values (stage 0).
  // Entry 0 is held at zero so x0 reads as "never pending".
  logic [1:0] cnt_p1 [32];
  logic [1:0] nxt_p0 [32];
  logic [1:0] eff_p0 [32];
  logic       accept_p0;
  logic       err_set_p0;
  logic       any_next_p0;

  // Clamp a net count into 0..3; bit 2 of the result flags that clamping occurred.
  function automatic logic [2:0] sat_cnt(input logic signed [3:0] v);
    if (v < 4'sd0)      return {1'b1, 2'd0};
    else if (v > 4'sd3) return {1'b1, 2'd3};
    else                return {1'b0, v[1:0]};
  endfunction

  // ---- stage 0: combinational hazard view and next-count computation ----

  // Effective count seen by ID: a same-cycle writeback is already visible.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      eff_p0[r] = cnt_p1[r];
      if (r != 0 && wb_valid && wb_rd == 5'(r) && cnt_p1[r] != 2'd0)
        eff_p0[r] = cnt_p1[r] - 2'd1;
    end
  end

  // Stall on a pending source operand or when the destination counter is full.
  assign is_stall = (rs1_id != 5'd0 && eff_p0[rs1_id] != 2'd0) ||
                    (rs2_id != 5'd0 && eff_p0[rs2_id] != 2'd0) ||
                    (issue_valid && issue_reg_write && issue_rd != 5'd0 &&
                     eff_p0[issue_rd] == 2'd3);

  assign accept_p0 = issue_valid && issue_reg_write && issue_rd != 5'd0 && !is_stall;

  // Net increment/decrement per register, saturated, with error collection.
  always_comb begin : next_count
    logic              inc;
    logic              dec_wb;
    logic              dec_kill;
    logic signed [3:0] sum;
    logic [2:0]        sat;
    err_set_p0  = 1'b0;
    any_next_p0 = 1'b0;
    inc         = 1'b0;
    dec_wb      = 1'b0;
    dec_kill    = 1'b0;
    sum         = '0;
    sat         = '0;
    for (int r = 0; r < 32; r++) begin
      nxt_p0[r] = 2'd0;
      if (r != 0) begin
        inc      = accept_p0 && issue_rd == 5'(r);
        dec_wb   = wb_valid && wb_rd == 5'(r);
        dec_kill = kill_valid && kill_rd == 5'(r);
        sum      = $signed({2'b00, cnt_p1[r]}) + $signed({3'b000, inc})
                 - $signed({3'b000, dec_wb}) - $signed({3'b000, dec_kill});
        sat         = sat_cnt(sum);
        nxt_p0[r]   = sat[1:0];
        err_set_p0  = err_set_p0 | sat[2];
        any_next_p0 = any_next_p0 | (sat[1:0] != 2'd0);
      end
    end
  end

  // ---- stage 1: counter state, pending summary and sticky error ----

  // Counters and flags; reset discards all outstanding writes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) cnt_p1[r] <= 2'd0;
      pending_any <= 1'b0;
      sb_error    <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_p1[r] <= nxt_p0[r];
      pending_any <= any_next_p0;
      sb_error    <= sb_error | err_set_p0;
    end
  end

endmodule
